fpga_fifo_push_arb: RTL and testbench

FPGA_FIFO_PUSH_ARB -- requirements
Module: fpga_fifo_push_arb

---
 rtl/fpga_fifo_arb_pkg.sv | 21 ++
 rtl/rr_prio_sel.sv | 37 +++
 rtl/fpga_fifo_push_arb.sv | 126 ++++++++++++
 tb/tb_fpga_fifo_push_arb.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_fifo_arb_pkg.sv
// Shared types for the FIFO push arbiter.
// Defining FPGA_FIFO_ARB_ID_TAG_EN prepends the served requester index to each pushed word.
package fpga_fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    FLUSH  = 2'd2
  } arb_state_e;

`ifdef FPGA_FIFO_ARB_ID_TAG_EN
  localparam bit TagEn = 1'b1;
`else
  localparam bit TagEn = 1'b0;
`endif

  function automatic int tag_width(input int id_w);
    return TagEn ? id_w : 0;
  endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// Combinational find-first selector: first set request at or above ptr, wrapping to 0.
module rr_prio_sel
  import fpga_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IdW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdW-1:0]     idx,
  output logic               found
);

  int             cand;
  logic [IdW-1:0] cand_idx;

  // Scan from the farthest offset down so the nearest request to ptr wins last.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand     = (int'(ptr) + off) % NUM_REQ;
      cand_idx = IdW'(cand);
      if (req[cand_idx]) begin
        gnt           = '0;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_fifo_push_arb.sv
// Round-robin, burst-locking arbiter pushing requester beats into one FIFO, with flush handshake.
// Build option: FPGA_FIFO_ARB_ID_TAG_EN tags each pushed word with the served requester index.
module fpga_fifo_push_arb
  import fpga_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IdW        = $clog2(NUM_REQ),
  localparam int TagW       = tag_width(IdW)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          flush_req_i,
  output logic                          flush_ack_o,
  output logic                          fifo_push_o,
  output logic [TagW+DATA_WIDTH-1:0]    fifo_data_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_flush_o,
  output logic [IdW-1:0]                grant_id_o,
  output logic                          busy_o
);

  arb_state_e          state, state_nxt;
  logic [IdW-1:0]      rr_ptr, rr_ptr_nxt;
  logic [IdW-1:0]      lock_id, lock_id_nxt;
  logic [NUM_REQ-1:0]  sel_gnt;
  logic [IdW-1:0]      sel_idx;
  logic                sel_found;
  logic                accept;
  logic                flush_c;
  logic [IdW-1:0]      srv_id;
  logic [NUM_REQ-1:0]  ready_c;
  logic [DATA_WIDTH-1:0] payload;

  function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + IdW'(1);
  endfunction

  rr_prio_sel #(.NUM_REQ(NUM_REQ)) u_sel (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .gnt   (sel_gnt),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  // A full FIFO freezes IDLE/LOCKED entirely, including a pending flush; FLUSH always lasts one cycle.
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_id_nxt = lock_id;
    accept      = 1'b0;
    flush_c     = 1'b0;
    srv_id      = '0;
    ready_c     = '0;
    case (state)
      IDLE: begin
        if (!fifo_full_i) begin
          if (flush_req_i) begin
            state_nxt = FLUSH;
          end else if (sel_found) begin
            accept  = 1'b1;
            srv_id  = sel_idx;
            ready_c = sel_gnt;
            if (req_last_i[sel_idx]) begin
              rr_ptr_nxt = wrap_inc(sel_idx);
            end else begin
              state_nxt   = LOCKED;
              lock_id_nxt = sel_idx;
            end
          end
        end
      end
      LOCKED: begin
        if (req_valid_i[lock_id] && !fifo_full_i) begin
          accept           = 1'b1;
          srv_id           = lock_id;
          ready_c[lock_id] = 1'b1;
          if (req_last_i[lock_id]) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(lock_id);
          end
        end
      end
      FLUSH: begin
        flush_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign payload = req_data_i[srv_id*DATA_WIDTH +: DATA_WIDTH];

  // Outputs are forced low while reset is asserted so an abandoned burst or flush leaves no strobe.
  assign fifo_push_o  = accept & ~rst_i;
  assign req_ready_o  = rst_i ? '0 : ready_c;
  assign grant_id_o   = fifo_push_o ? srv_id : '0;
  assign fifo_flush_o = flush_c & ~rst_i;
  assign flush_ack_o  = flush_c & ~rst_i;
  assign busy_o       = (state != IDLE) & ~rst_i;

`ifdef FPGA_FIFO_ARB_ID_TAG_EN
  assign fifo_data_o = fifo_push_o ? {srv_id, payload} : '0;
`else
  assign fifo_data_o = fifo_push_o ? payload : '0;
`endif

endmodule

// File: tb/tb_fpga_fifo_push_arb.sv
// Bench for fpga_fifo_push_arb: directed scenarios plus randomized traffic against a reference model.
module tb_fpga_fifo_push_arb;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;
`ifdef FPGA_FIFO_ARB_ID_TAG_EN
  localparam int TW = IDW;
`else
  localparam int TW = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            flush_req, flush_ack, fifo_push, fifo_full, fifo_flush, busy;
  logic [TW+DW-1:0] fifo_data;
  logic [IDW-1:0]  grant_id;

  int total = 0;
  int bad   = 0;

  // Reference model state: current burst owner (-1 when none), round-robin start, flush cycle flag.
  int  m_owner, m_ptr, m_srv;
  bit  m_flushing;
  logic            e_push, e_flush, e_busy;
  logic [N-1:0]    e_ready;
  logic [IDW-1:0]  e_id;
  logic [TW+DW-1:0] e_data;

  fpga_fifo_push_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_last_i   (req_last),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .flush_req_i  (flush_req),
    .flush_ack_o  (flush_ack),
    .fifo_push_o  (fifo_push),
    .fifo_data_o  (fifo_data),
    .fifo_full_i  (fifo_full),
    .fifo_flush_o (fifo_flush),
    .grant_id_o   (grant_id),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    m_srv   = -1;
    e_flush = 1'b0;
    if (rst) begin
      m_srv = -1;
    end else if (m_flushing) begin
      e_flush = 1'b1;
    end else if (m_owner >= 0) begin
      if (req_valid[m_owner] && !fifo_full) m_srv = m_owner;
    end else if (!fifo_full && !flush_req) begin
      for (int k = 0; k < N; k++)
        if (m_srv < 0 && req_valid[(m_ptr + k) % N]) m_srv = (m_ptr + k) % N;
    end
    e_push  = (m_srv >= 0);
    e_ready = e_push ? (N'(1) << m_srv) : '0;
    e_id    = e_push ? IDW'(m_srv) : '0;
    e_busy  = !rst && (m_owner >= 0 || m_flushing);
    e_data  = '0;
    if (e_push) begin
      e_data[DW-1:0] = req_data[m_srv*DW +: DW];
`ifdef FPGA_FIFO_ARB_ID_TAG_EN
      e_data[TW+DW-1:DW] = IDW'(m_srv);
`endif
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_flushing = 1'b0;
    end else if (m_flushing) begin
      m_flushing = 1'b0;
    end else if (m_owner >= 0) begin
      if (m_srv >= 0 && req_last[m_srv]) begin
        m_ptr   = (m_srv + 1) % N;
        m_owner = -1;
      end
    end else if (flush_req) begin
      if (!fifo_full) m_flushing = 1'b1;
    end else if (m_srv >= 0) begin
      if (req_last[m_srv]) m_ptr = (m_srv + 1) % N;
      else m_owner = m_srv;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_last = '0; flush_req = 1'b0; fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    settle();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_last = 4'hF; flush_req = 1'b1; fifo_full = 1'b0;
    settle();
    total++;
    if ({fifo_push, req_ready, fifo_flush, flush_ack, busy} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: push=%b ready=%b flush=%b ack=%b busy=%b, want all 0",
               fifo_push, req_ready, fifo_flush, flush_ack, busy);
    end
    total++;
    if (grant_id !== '0 || fifo_data !== '0) begin
      bad++;
      $display("FAIL reset_data: id=%0d data=%h, want 0", grant_id, fifo_data);
    end
    advance();
    rst = 1'b0;
    clear_inputs();
    settle();
    total++;
    if ({fifo_push, req_ready, fifo_flush, flush_ack, busy} !== 8'h00) begin
      bad++;
      $display("FAIL post_reset_idle: push=%b ready=%b flush=%b busy=%b, want all 0",
               fifo_push, req_ready, fifo_flush, busy);
    end
    advance();
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'hF; req_last = 4'hF;
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = 32'h1000_0000 + k;
    for (int i = 0; i < 5; i++) begin
      settle();
      total++;
      if (fifo_push !== 1'b1 || grant_id !== IDW'(i % N) || req_ready !== (N'(1) << (i % N))) begin
        bad++;
        $display("FAIL rr_order beat %0d: push=%b id=%0d ready=%b, want push=1 id=%0d", i,
                 fifo_push, grant_id, req_ready, i % N);
      end
      total++;
      if (fifo_data[DW-1:0] !== 32'h1000_0000 + (i % N)) begin
        bad++;
        $display("FAIL rr_data beat %0d: data=%h want %h", i, fifo_data[DW-1:0], 32'h1000_0000 + (i % N));
      end
      advance();
    end
  endtask

  task automatic test_burst();
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0001;
    settle();
    advance();
    req_valid = 4'b0111;
    for (int b = 0; b < 3; b++) begin
      req_last = (b == 2) ? 4'b0111 : 4'b0101;
      settle();
      total++;
      if (fifo_push !== 1'b1 || grant_id !== 2'd1 || req_ready !== 4'b0010) begin
        bad++;
        $display("FAIL burst_lock beat %0d: push=%b id=%0d ready=%b, want id=1 ready=0010", b,
                 fifo_push, grant_id, req_ready);
      end
      advance();
    end
    req_valid = 4'b0101; req_last = 4'b0101;
    settle();
    total++;
    if (fifo_push !== 1'b1 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL burst_next: push=%b id=%0d, want id=2", fifo_push, grant_id);
    end
    advance();
  endtask

  task automatic test_full_stall();
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0000;
    settle();
    advance();
    fifo_full = 1'b1; req_valid = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      settle();
      total++;
      if (fifo_push !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL full_hold cycle %0d: push=%b ready=%b busy=%b, want 0/0000/1", c,
                 fifo_push, req_ready, busy);
      end
      advance();
    end
    fifo_full = 1'b0; req_last = 4'b0001;
    settle();
    total++;
    if (fifo_push !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL full_resume: push=%b id=%0d ready=%b, want 1/0/0001", fifo_push, grant_id, req_ready);
    end
    advance();
    req_valid = '0;
    settle();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL full_end_idle: busy=%b want 0", busy);
    end
    advance();
  endtask

  task automatic test_flush_idle();
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0001; flush_req = 1'b1;
    settle();
    total++;
    if (fifo_push !== 1'b0 || req_ready !== 4'b0000 || fifo_flush !== 1'b0) begin
      bad++;
      $display("FAIL flush_priority: push=%b ready=%b flush=%b, want all 0", fifo_push, req_ready, fifo_flush);
    end
    advance();
    settle();
    total++;
    if (fifo_flush !== 1'b1 || flush_ack !== 1'b1 || fifo_push !== 1'b0) begin
      bad++;
      $display("FAIL flush_strobe: flush=%b ack=%b push=%b, want 1/1/0", fifo_flush, flush_ack, fifo_push);
    end
    advance();
    flush_req = 1'b0;
    settle();
    total++;
    if (fifo_push !== 1'b1 || grant_id !== 2'd0 || fifo_flush !== 1'b0) begin
      bad++;
      $display("FAIL flush_then_serve: push=%b id=%0d flush=%b, want 1/0/0", fifo_push, grant_id, fifo_flush);
    end
    advance();
  endtask

  task automatic test_flush_deferred();
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000;
    settle();
    advance();
    flush_req = 1'b1;
    for (int b = 1; b < 4; b++) begin
      req_last = (b == 3) ? 4'b0100 : 4'b0000;
      settle();
      total++;
      if (fifo_push !== 1'b1 || grant_id !== 2'd2 || fifo_flush !== 1'b0) begin
        bad++;
        $display("FAIL flush_defer beat %0d: push=%b id=%0d flush=%b, want 1/2/0", b,
                 fifo_push, grant_id, fifo_flush);
      end
      advance();
    end
    req_valid = '0;
    settle();
    advance();
    settle();
    total++;
    if (fifo_flush !== 1'b1 || flush_ack !== 1'b1 || fifo_push !== 1'b0) begin
      bad++;
      $display("FAIL flush_after_burst: flush=%b ack=%b push=%b, want 1/1/0", fifo_flush, flush_ack, fifo_push);
    end
    advance();
    flush_req = 1'b0;
    settle();
    total++;
    if (fifo_flush !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_single: flush=%b busy=%b, want 0/0", fifo_flush, busy);
    end
    advance();
  endtask

  task automatic test_tag_and_reset_locked();
    logic [TW+DW-1:0] want;
`ifdef FPGA_FIFO_ARB_ID_TAG_EN
    want = {2'd3, 32'hDEADBEEF};
`else
    want = 32'hDEADBEEF;
`endif
    do_reset();
    req_valid = 4'b1000; req_last = 4'b0000; req_data[3*DW +: DW] = 32'hDEADBEEF;
    settle();
    total++;
    if (fifo_push !== 1'b1 || fifo_data !== want || grant_id !== 2'd3) begin
      bad++;
      $display("FAIL tag_data: push=%b data=%h id=%0d, want data=%h id=3", fifo_push, fifo_data, grant_id, want);
    end
    advance();
    rst = 1'b1;
    settle();
    total++;
    if ({fifo_push, req_ready, fifo_flush, flush_ack, busy} !== 8'h00 || fifo_data !== '0) begin
      bad++;
      $display("FAIL reset_in_locked: push=%b ready=%b busy=%b data=%h, want all 0",
               fifo_push, req_ready, busy, fifo_data);
    end
    advance();
    rst = 1'b0; req_valid = 4'b0001; req_last = 4'b0001;
    settle();
    total++;
    if (fifo_push !== 1'b1 || grant_id !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_abandon: push=%b id=%0d busy=%b, want 1/0/0", fifo_push, grant_id, busy);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) < 2);
      req_valid = 4'($urandom);
      req_last  = 4'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      fifo_full = ($urandom_range(0, 3) == 0);
      flush_req = ($urandom_range(0, 9) == 0);
      settle();
      total++;
      if (fifo_push !== e_push || req_ready !== e_ready) begin
        bad++;
        $display("FAIL rand_push cycle %0d: push=%b ready=%b, want %b %b", c, fifo_push, req_ready, e_push, e_ready);
      end
      total++;
      if (e_push && (grant_id !== e_id || fifo_data !== e_data)) begin
        bad++;
        $display("FAIL rand_data cycle %0d: id=%0d data=%h, want %0d %h", c, grant_id, fifo_data, e_id, e_data);
      end
      total++;
      if (fifo_flush !== e_flush || flush_ack !== e_flush || busy !== e_busy) begin
        bad++;
        $display("FAIL rand_ctrl cycle %0d: flush=%b ack=%b busy=%b, want %b %b %b", c,
                 fifo_flush, flush_ack, busy, e_flush, e_flush, e_busy);
      end
      advance();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_owner = -1; m_ptr = 0; m_flushing = 1'b0; m_srv = -1;
    rst = 1'b1; req_data = '0;
    clear_inputs();
    #1;
    test_reset();
    test_round_robin();
    test_burst();
    test_full_stall();
    test_flush_idle();
    test_flush_deferred();
    test_tag_and_reset_locked();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
